// File: rtl/battle_pkg.sv
// Shared types and helpers for the naval-battle board controller.
//   state_t  : FSM state codes (SETUP=0, PLAY=1, OVER=2)
//   idx      : row/column to flat cell index (r*cols + c)
//   popcount : number of set bits in a board vector, zero-extended to MAX_CELLS
package battle_pkg;

  typedef enum logic [1:0] {
    SETUP = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } state_t;

  // Largest board the popcount helper covers; boards are zero-extended to this.
  localparam int MAX_CELLS = 256;
  localparam int POP_W     = 9;

  function automatic int idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [MAX_CELLS-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_CELLS; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/battle_btn_edge.sv
// Push-button qualifier: two-flop synchroniser followed by a falling-edge
// detector. A held button yields exactly one o_press pulse; no debounce here.
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset (flops preset to "released")
//   i_btn_n  in  raw active-low button, asynchronous to clk
//   o_press  out one-cycle pulse, three clk edges after the press reaches the pin
module battle_btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_press
);

  logic r_sync_p0;
  logic r_sync_p1;
  logic r_sync_p2;
  logic r_press_p3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_p0  <= 1'b1;
      r_sync_p1  <= 1'b1;
      r_sync_p2  <= 1'b1;
      r_press_p3 <= 1'b0;
    end else begin
      // p0/p1: metastability synchroniser
      r_sync_p0  <= i_btn_n;
      r_sync_p1  <= r_sync_p0;
      // p2: previous synchronised level for edge detection
      r_sync_p2  <= r_sync_p1;
      // p3: registered high-to-low transition
      r_press_p3 <= r_sync_p2 & ~r_sync_p1;
    end
  end

  assign o_press = r_press_p3;

endmodule

// File: rtl/battle_board_ctrl.sv
// Naval-battle game-board controller: holds the ship-position and attack
// matrices, runs the SETUP/PLAY/OVER game flow, judges shots, counts hits and
// shots, flashes the RGB indicator and scans the LED matrix column by column.
// Ports:
//   clk, clr             clock, asynchronous active-low reset
//   button_confirmation  raw active-low confirm button
//   restart              in OVER, returns to SETUP
//   board_in             ship layout, bit r*COLS+c = cell (r,c)
//   at_row, at_col       shot coordinates
//   view_sel             LED view: 0 = ships, 1 = attacks
//   m_col, m_line        one-hot column drive and its line data
//   rgb_r, rgb_g         hit / miss flash
//   hits, shots          game counters
//   invalid              one-cycle pulse on a rejected confirm
//   state_out, game_over FSM state code and OVER flag
module battle_board_ctrl
  import battle_pkg::*;
#(
  parameter int ROWS         = 7,
  parameter int COLS         = 5,
  parameter int SCAN_DIV     = 50000,
  parameter int FLASH_CYCLES = 25000000,
  localparam int CW          = $clog2(ROWS*COLS+1)
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     button_confirmation,
  input  logic                     restart,
  input  logic [ROWS*COLS-1:0]     board_in,
  input  logic [$clog2(ROWS)-1:0]  at_row,
  input  logic [$clog2(COLS)-1:0]  at_col,
  input  logic                     view_sel,
  output logic [COLS-1:0]          m_col,
  output logic [ROWS-1:0]          m_line,
  output logic                     rgb_r,
  output logic                     rgb_g,
  output logic [CW-1:0]            hits,
  output logic [CW-1:0]            shots,
  output logic                     invalid,
  output logic [1:0]               state_out,
  output logic                     game_over
);

  localparam int NC  = ROWS * COLS;
  localparam int IW  = $clog2(NC);
  localparam int CLW = $clog2(COLS);
  localparam int PW  = $clog2(SCAN_DIV + 1);
  localparam int FW  = $clog2(FLASH_CYCLES + 1);

  logic            w_press;
  state_t          r_state;
  state_t          w_state_nxt;
  logic [NC-1:0]   r_pos;
  logic [NC-1:0]   r_attack;
  logic [CW-1:0]   r_hits;
  logic [CW-1:0]   r_shots;
  logic [CW-1:0]   r_ship_total;
  logic            r_rgb_r;
  logic            r_rgb_g;
  logic            r_invalid;
  logic [FW-1:0]   r_flash;
  logic [PW-1:0]   r_presc;
  logic [CLW-1:0]  r_col;
  logic [COLS-1:0] r_mcol;
  logic [ROWS-1:0] r_mline;

  logic            w_in_range;
  logic [IW-1:0]   w_cell;
  logic            w_setup_ok;
  logic            w_shot_ok;
  logic            w_hit;
  logic            w_reject;
  logic [CW-1:0]   w_board_pop;
  logic [CW-1:0]   w_hits_inc;
  logic [CLW-1:0]  w_col_nxt;
  logic [ROWS-1:0] w_line_nxt;
  logic [NC-1:0]   w_view;
  logic [COLS-1:0] w_one;

  battle_btn_edge u_btn (
    .clk     (clk),
    .rst_n   (clr),
    .i_btn_n (button_confirmation),
    .o_press (w_press)
  );

  // ---- Shot decode ----
  assign w_board_pop = CW'(popcount(MAX_CELLS'(board_in)));
  assign w_in_range  = (int'(at_row) < ROWS) && (int'(at_col) < COLS);
  // Out-of-range coordinates are parked on cell 0 so the matrix index stays legal;
  // w_in_range already vetoes such a shot.
  assign w_cell      = w_in_range ? IW'(idx(int'(at_row), int'(at_col), COLS)) : '0;
  assign w_hits_inc  = r_hits + CW'(1);
  assign w_hit       = w_shot_ok & r_pos[w_cell];

  always_comb begin
    w_state_nxt = r_state;
    w_setup_ok  = 1'b0;
    w_shot_ok   = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      SETUP: begin
        if (w_press) begin
          if (w_board_pop == '0) begin
            w_reject = 1'b1;
          end else begin
            w_setup_ok  = 1'b1;
            w_state_nxt = PLAY;
          end
        end
      end
      PLAY: begin
        if (w_press) begin
          if (!w_in_range || r_attack[w_cell]) begin
            w_reject = 1'b1;
          end else begin
            w_shot_ok = 1'b1;
            // Game ends on the edge that records the last ship hit.
            if (r_pos[w_cell] && (w_hits_inc == r_ship_total)) w_state_nxt = OVER;
          end
        end
      end
      OVER: begin
        if (restart) w_state_nxt = SETUP;
      end
      default: w_state_nxt = SETUP;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= SETUP;
    else      r_state <= w_state_nxt;
  end

  // ---- Board state and counters ----
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_pos        <= '0;
      r_attack     <= '0;
      r_hits       <= '0;
      r_shots      <= '0;
      r_ship_total <= '0;
      r_invalid    <= 1'b0;
    end else begin
      r_invalid <= w_reject;
      if (w_setup_ok) begin
        r_pos        <= board_in;
        r_ship_total <= w_board_pop;
        r_attack     <= '0;
        r_hits       <= '0;
        r_shots      <= '0;
      end else if (w_shot_ok) begin
        r_attack[w_cell] <= 1'b1;
        r_shots          <= r_shots + CW'(1);
        if (w_hit) r_hits <= w_hits_inc;
      end
    end
  end

  // ---- RGB flash ----
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_flash <= '0;
      r_rgb_r <= 1'b0;
      r_rgb_g <= 1'b0;
    end else if (w_shot_ok) begin
      r_flash <= FW'(FLASH_CYCLES);
      r_rgb_r <= w_hit;
      r_rgb_g <= ~w_hit;
    end else if (r_flash != '0) begin
      r_flash <= r_flash - FW'(1);
      if (r_flash == FW'(1)) begin
        r_rgb_r <= 1'b0;
        r_rgb_g <= 1'b0;
      end
    end
  end

  // ---- LED matrix scan ----
  assign w_one     = {{(COLS-1){1'b0}}, 1'b1};
  assign w_view    = view_sel ? r_attack : r_pos;
  assign w_col_nxt = (int'(r_col) == COLS-1) ? '0 : r_col + CLW'(1);

  // Line data is taken for the column about to be shown so that m_col and
  // m_line always switch together.
  always_comb begin
    w_line_nxt = '0;
    for (int r = 0; r < ROWS; r++) begin
      w_line_nxt[r] = w_view[IW'(idx(r, int'(w_col_nxt), COLS))];
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_presc <= '0;
      r_col   <= '0;
      r_mcol  <= w_one;
      r_mline <= '0;
    end else if (r_presc == PW'(SCAN_DIV - 1)) begin
      r_presc <= '0;
      r_col   <= w_col_nxt;
      r_mcol  <= w_one << w_col_nxt;
      r_mline <= w_line_nxt;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  assign m_col     = r_mcol;
  assign m_line    = r_mline;
  assign rgb_r     = r_rgb_r;
  assign rgb_g     = r_rgb_g;
  assign hits      = r_hits;
  assign shots     = r_shots;
  assign invalid   = r_invalid;
  assign state_out = r_state;
  assign game_over = (r_state == OVER);

endmodule

// File: tb/tb_battle_board_ctrl.sv
module tb_battle_board_ctrl;

  localparam int ROWS  = 7;
  localparam int COLS  = 5;
  localparam int SDIV  = 4;
  localparam int FLASH = 12;
  localparam int NC    = ROWS * COLS;
  localparam int CW    = $clog2(NC + 1);

  logic            clk = 1'b0;
  logic            clr = 1'b0;
  logic            btn = 1'b1;
  logic            restart = 1'b0;
  logic            view_sel = 1'b0;
  logic [NC-1:0]   board_in = '0;
  logic [2:0]      at_row = '0;
  logic [2:0]      at_col = '0;
  logic [COLS-1:0] m_col;
  logic [ROWS-1:0] m_line;
  logic            rgb_r, rgb_g, invalid, game_over;
  logic [CW-1:0]   hits, shots;
  logic [1:0]      state_out;

  always #5 clk = ~clk;

  battle_board_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV), .FLASH_CYCLES(FLASH)
  ) dut (
    .clk(clk), .clr(clr), .button_confirmation(btn), .restart(restart),
    .board_in(board_in), .at_row(at_row), .at_col(at_col), .view_sel(view_sel),
    .m_col(m_col), .m_line(m_line), .rgb_r(rgb_r), .rgb_g(rgb_g),
    .hits(hits), .shots(shots), .invalid(invalid), .state_out(state_out),
    .game_over(game_over)
  );

  int checks = 0;
  int failures = 0;
  int inv_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: board as 2-D arrays, game rules as plain integers.
  bit ship[ROWS][COLS];
  bit att[ROWS][COLS];
  int m_mode, m_hits, m_shots, m_total, m_flash, m_r, m_g, m_inv;
  int m_scan, m_colidx, m_line_exp;
  bit pin_h[1:4];   // pin_h[k] = button pin sampled k edges ago

  task automatic model_reset();
    foreach (ship[r, c]) begin ship[r][c] = 0; att[r][c] = 0; end
    m_mode = 0; m_hits = 0; m_shots = 0; m_total = 0;
    m_flash = 0; m_r = 0; m_g = 0; m_inv = 0;
    m_scan = 0; m_colidx = 0; m_line_exp = 0;
    for (int k = 1; k <= 4; k++) pin_h[k] = 1'b1;
  endtask

  task automatic model_step();
    bit conf, hit, fired, ok;
    int pop, rr, cc;
    // A press acts on the fourth edge after the pin is first sampled low.
    conf = !pin_h[3] && pin_h[4];
    pin_h[4] = pin_h[3]; pin_h[3] = pin_h[2]; pin_h[2] = pin_h[1]; pin_h[1] = btn;
    m_scan++;
    if (m_scan == SDIV) begin
      m_scan = 0;
      m_colidx = (m_colidx + 1) % COLS;
      m_line_exp = 0;
      for (int r = 0; r < ROWS; r++)
        if (view_sel ? att[r][m_colidx] : ship[r][m_colidx]) m_line_exp |= (1 << r);
    end
    m_inv = 0; fired = 0; hit = 0;
    rr = int'(at_row); cc = int'(at_col);
    case (m_mode)
      0: if (conf) begin
        pop = 0;
        for (int i = 0; i < NC; i++) pop += int'(board_in[i]);
        if (pop == 0) m_inv = 1;
        else begin
          for (int i = 0; i < NC; i++) begin
            ship[i / COLS][i % COLS] = board_in[i];
            att[i / COLS][i % COLS] = 0;
          end
          m_total = pop; m_hits = 0; m_shots = 0; m_mode = 1;
        end
      end
      1: if (conf) begin
        ok = (rr < ROWS) && (cc < COLS);
        if (ok) ok = !att[rr][cc];
        if (!ok) m_inv = 1;
        else begin
          att[rr][cc] = 1; m_shots++; fired = 1; hit = ship[rr][cc];
          if (hit) m_hits++;
          if (hit && m_hits == m_total) m_mode = 2;
        end
      end
      default: if (restart) m_mode = 0;
    endcase
    if (fired) begin
      m_flash = FLASH; m_r = hit; m_g = !hit;
    end else if (m_flash > 0) begin
      m_flash--;
      if (m_flash == 0) begin m_r = 0; m_g = 0; end
    end
  endtask

  // Model advances on every rising edge; DUT compared on every falling edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!clr) model_reset(); else model_step();
      @(negedge clk);
      if (invalid === 1'b1) inv_seen++;
      chk("state", 32'(state_out), m_mode);
      chk("hits", 32'(hits), m_hits);
      chk("shots", 32'(shots), m_shots);
      chk("invalid", 32'(invalid), m_inv);
      chk("rgb_r", 32'(rgb_r), m_r);
      chk("rgb_g", 32'(rgb_g), m_g);
      chk("game_over", 32'(game_over), int'(m_mode == 2));
      chk("m_col", 32'(m_col), 1 << m_colidx);
      chk("m_line", 32'(m_line), m_line_exp);
    end
  end

  task automatic press(input int low_n, input int high_n);
    @(negedge clk); #1 btn = 1'b0;
    repeat (low_n) @(negedge clk);
    #1 btn = 1'b1;
    repeat (high_n) @(negedge clk);
    #1;
  endtask

  task automatic fire(input int r, input int c);
    at_row = 3'(r); at_col = 3'(c);
    press(3, 4);
  endtask

  int inv0, prev_col, found, exp_col;
  int ships_q[$];
  int k;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state_out), 0);
    chk("rst_mcol", 32'(m_col), 1);
    chk("rst_hits", 32'(hits), 0);
    #1 clr = 1'b1;

    // Empty board is rejected
    inv0 = inv_seen;
    press(3, 4);
    chk("empty_inv_pulses", 32'(inv_seen - inv0), 1);
    chk("empty_state", 32'(state_out), 0);

    // Two ships: (0,0) and (2,3)
    board_in = '0; board_in[0] = 1'b1; board_in[13] = 1'b1;
    press(3, 4);
    chk("load_state", 32'(state_out), 1);
    chk("load_hits", 32'(hits), 0);

    fire(2, 3);
    chk("hit_hits", 32'(hits), 1);
    chk("hit_shots", 32'(shots), 1);
    chk("hit_rgb_r", 32'(rgb_r), 1);
    chk("hit_rgb_g", 32'(rgb_g), 0);

    inv0 = inv_seen;
    fire(2, 3);
    chk("dup_inv_pulses", 32'(inv_seen - inv0), 1);
    chk("dup_shots", 32'(shots), 1);

    inv0 = inv_seen;
    fire(7, 0);
    chk("oor_inv_pulses", 32'(inv_seen - inv0), 1);
    chk("oor_shots", 32'(shots), 1);

    fire(4, 4);
    chk("miss_rgb_g", 32'(rgb_g), 1);
    chk("miss_rgb_r", 32'(rgb_r), 0);
    chk("miss_shots", 32'(shots), 2);
    repeat (FLASH + 2) @(negedge clk);
    chk("flash_off", 32'(rgb_g), 0);

    fire(0, 0);
    chk("over_hits", 32'(hits), 2);
    chk("over_flag", 32'(game_over), 1);
    chk("over_state", 32'(state_out), 2);

    inv0 = inv_seen;
    press(3, 4);
    chk("over_press_inv", 32'(inv_seen - inv0), 0);
    chk("over_press_state", 32'(state_out), 2);

    restart = 1'b1;
    @(negedge clk);
    chk("restart_state", 32'(state_out), 0);
    #1 restart = 1'b0;

    // Scan order, one column every SDIV clocks
    view_sel = 1'b0;
    prev_col = int'(m_col); found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (m_col == 5'b00001 && prev_col != 1) found = 1;
      else prev_col = int'(m_col);
    end
    chk("scan_sync", 32'(found), 1);
    for (int s = 1; s <= 5; s++) begin
      repeat (SDIV) @(negedge clk);
      exp_col = (s == 5) ? 1 : (1 << s);
      chk("scan_col", 32'(m_col), exp_col);
    end
    chk("line_c0_ships", 32'(m_line), 1);
    #1 view_sel = 1'b1;
    repeat (3 * SDIV) @(negedge clk);
    chk("line_c3_attack", 32'(m_line), 4);
    repeat (SDIV) @(negedge clk);
    chk("line_c4_attack", 32'(m_line), 16);
    #1 view_sel = 1'b0;
    repeat (SDIV) @(negedge clk);
    chk("line_c0_ships2", 32'(m_line), 1);

    // Randomized games
    for (int g = 0; g < 4; g++) begin
      board_in = '0;
      k = $urandom_range(1, 3);
      for (int i = 0; i < k; i++) board_in[$urandom_range(0, NC - 1)] = 1'b1;
      press($urandom_range(1, 4), $urandom_range(2, 5));
      ships_q = {};
      for (int i = 0; i < NC; i++) if (ship[i / COLS][i % COLS]) ships_q.push_back(i);
      for (int s = 0; s < 80 && m_mode == 1; s++) begin
        if ($urandom_range(0, 1) == 1 && ships_q.size() > 0) begin
          k = ships_q[$urandom_range(0, ships_q.size() - 1)];
          at_row = 3'(k / COLS); at_col = 3'(k % COLS);
        end else begin
          at_row = 3'($urandom_range(0, 7)); at_col = 3'($urandom_range(0, 7));
        end
        view_sel = 1'($urandom_range(0, 1));
        restart = 1'($urandom_range(0, 1));
        press($urandom_range(1, 4), $urandom_range(1, 6));
        restart = 1'b0;
      end
      press(2, 3);
      restart = 1'b1;
      @(negedge clk); #1 restart = 1'b0;
      repeat ($urandom_range(1, 10)) @(negedge clk);
    end

    // Reset in the middle of a game after three hits
    #1 clr = 1'b0;
    @(negedge clk); #1 clr = 1'b1;
    board_in = '0; board_in[3:0] = 4'b1111;
    press(3, 4);
    fire(0, 0); fire(0, 1); fire(0, 2);
    chk("mid_hits", 32'(hits), 3);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("mid_rst_hits", 32'(hits), 0);
    chk("mid_rst_shots", 32'(shots), 0);
    chk("mid_rst_state", 32'(state_out), 0);
    chk("mid_rst_mcol", 32'(m_col), 1);
    chk("mid_rst_rgb", 32'({rgb_r, rgb_g}), 0);
    #1 clr = 1'b1;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
